// File: rtl/n64adv_vin_demux.sv
// n64adv_vin_demux
// Front stage of the N64 video path. Collects the byte-serial video bus
// (sync byte, then R, G, B) into one parallel pixel word with a valid strobe,
// and measures lines per field to classify PAL/NTSC and progressive/interlaced.

module n64adv_vin_demux #(
    parameter int color_width_i = 7,
    parameter int line_cnt_w    = 10,
    parameter int pal_thresh    = 288
) (
    input  logic                         VCLK,
    input  logic                         nVRST,
    input  logic                         nVDSYNC,
    input  logic [color_width_i-1:0]     VD_i,
    output logic [3*color_width_i+3:0]   vdata_o,
    output logic                         vdata_valid_o,
    output logic                         palmode_o,
    output logic                         interlaced_o,
    output logic                         field_o,
    output logic                         vinfo_valid_o,
    output logic                         sync_err_o
);

    localparam logic [line_cnt_w-1:0] line_max  = '1;
    localparam logic [line_cnt_w-1:0] line_one  = line_cnt_w'(1);
    localparam logic [line_cnt_w-1:0] pal_lines = line_cnt_w'(pal_thresh);

    // SYNC is the post-reset wait for the first sync byte; IDLE follows a
    // complete pixel and tolerates one gap byte before flagging an error.
    typedef enum logic [2:0] {
        ST_SYNC,
        ST_R,
        ST_G,
        ST_B,
        ST_IDLE
    } phase_t;

    phase_t                    state;
    phase_t                    state_nxt;
    logic [1:0]                gap;
    logic [1:0]                gap_nxt;

    logic                      nvdsync_q;
    logic [color_width_i-1:0]  vd_q;

    logic                      cap_sync;
    logic                      cap_r;
    logic                      cap_g;
    logic                      cap_b;
    logic                      err_pulse;

    logic [3:0]                sync_bits;
    logic [color_width_i-1:0]  r_q;
    logic [color_width_i-1:0]  g_q;
    logic [3*color_width_i+3:0] pix_word;
    logic                      pix_pend;

    logic [line_cnt_w-1:0]     line_cnt;
    logic [line_cnt_w-1:0]     prev_cnt;
    logic [1:0]                field_cnt;
    logic                      hs_fall;
    logic                      vs_fall;
    logic                      lines_differ;

    // Register the bus once on entry; all decoding works on this copy.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge VCLK) begin
        if (!nVRST) begin
            nvdsync_q <= 1'b1;
            vd_q      <= '0;
        end else begin
            nvdsync_q <= nVDSYNC;
            vd_q      <= VD_i;
        end
    end

    // Phase state register and idle-gap counter.
    always_ff @(posedge VCLK) begin
        if (!nVRST) begin
            state <= ST_SYNC;
            gap   <= 2'd0;
        end else begin
            state <= state_nxt;
            gap   <= gap_nxt;
        end
    end

    // Next phase, capture enables and framing-error detection.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap;
        cap_sync  = 1'b0;
        cap_r     = 1'b0;
        cap_g     = 1'b0;
        cap_b     = 1'b0;
        err_pulse = 1'b0;
        if (!nvdsync_q) begin
            // A sync byte always restarts the frame; mid-pixel it is a short frame.
            cap_sync  = 1'b1;
            state_nxt = ST_R;
            gap_nxt   = 2'd0;
            err_pulse = (state == ST_R) || (state == ST_G) || (state == ST_B);
        end else begin
            case (state)
                ST_R: begin
                    cap_r     = 1'b1;
                    state_nxt = ST_G;
                end
                ST_G: begin
                    cap_g     = 1'b1;
                    state_nxt = ST_B;
                end
                ST_B: begin
                    cap_b     = 1'b1;
                    state_nxt = ST_IDLE;
                    gap_nxt   = 2'd0;
                end
                ST_IDLE: begin
                    // One gap byte is tolerated; the second reports once, then saturates.
                    err_pulse = (gap == 2'd1);
                    if (gap != 2'd2) begin
                        gap_nxt = gap + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sync bits and the pending-pixel flag; sync bits double as the
    // previous-byte reference for edge detection.
    always_ff @(posedge VCLK) begin
        if (!nVRST) begin
            sync_bits <= 4'hF;
            pix_pend  <= 1'b0;
        end else begin
            pix_pend <= cap_b;
            if (cap_sync) begin
                sync_bits <= vd_q[3:0];
            end
        end
    end

    // Colour byte holding registers and the assembled pixel word.
    // NOTE: pure data registers carry no reset; pix_pend qualifies their use,
    // so stale contents after reset are never presented.
    always_ff @(posedge VCLK) begin
        if (cap_r) begin
            r_q <= vd_q;
        end
        if (cap_g) begin
            g_q <= vd_q;
        end
        if (cap_b) begin
            pix_word <= {sync_bits, r_q, g_q, vd_q};
        end
    end

    // Pixel output register, valid strobe and framing-error strobe.
    always_ff @(posedge VCLK) begin
        if (!nVRST) begin
            vdata_o       <= {4'hF, {(3*color_width_i){1'b0}}};
            vdata_valid_o <= 1'b0;
            sync_err_o    <= 1'b0;
        end else begin
            vdata_valid_o <= pix_pend;
            sync_err_o    <= err_pulse;
            if (pix_pend) begin
                vdata_o <= pix_word;
            end
        end
    end

    // Sync edges between successive sync bytes (bit 3 = nVSYNC, bit 1 = nHSYNC).
    assign hs_fall      = cap_sync && sync_bits[1] && !vd_q[1];
    assign vs_fall      = cap_sync && sync_bits[3] && !vd_q[3];
    assign lines_differ = (line_cnt != prev_cnt);

    // Line counting and field classification; a field closes on the nVSYNC
    // fall before any coincident nHSYNC fall is counted into the new field.
    always_ff @(posedge VCLK) begin
        if (!nVRST) begin
            line_cnt      <= '0;
            prev_cnt      <= '0;
            field_cnt     <= 2'd0;
            palmode_o     <= 1'b0;
            interlaced_o  <= 1'b0;
            field_o       <= 1'b0;
            vinfo_valid_o <= 1'b0;
        end else if (vs_fall) begin
            prev_cnt <= line_cnt;
            line_cnt <= hs_fall ? line_one : '0;
            if (field_cnt != 2'd2) begin
                field_cnt <= field_cnt + 2'd1;
            end
            // The first close after reset ends a partial field; report from the second on.
            if (field_cnt != 2'd0) begin
                palmode_o     <= (line_cnt >= pal_lines);
                interlaced_o  <= lines_differ;
                field_o       <= lines_differ && line_cnt[0];
                vinfo_valid_o <= 1'b1;
            end
        end else if (hs_fall && (line_cnt != line_max)) begin
            line_cnt <= line_cnt + line_one;
        end
    end

endmodule

// File: tb/tb_n64adv_vin_demux.sv
// tb_n64adv_vin_demux
// Directed stimulus pushes expected pixels and error pulses into queues; a
// negedge monitor pops and compares whenever the DUT strobes an output.

module tb_n64adv_vin_demux;

    logic        VCLK;
    logic        nVRST;
    logic        nVDSYNC;
    logic [6:0]  VD_i;
    logic [24:0] vdata_o;
    logic        vdata_valid_o;
    logic        palmode_o;
    logic        interlaced_o;
    logic        field_o;
    logic        vinfo_valid_o;
    logic        sync_err_o;

    typedef struct {
        logic [24:0] vdata;
        logic [3:0]  status;   // {vinfo_valid, palmode, interlaced, field}
        int          due;
    } pix_t;

    pix_t pix_q[$];
    int   err_q[$];
    pix_t mon_e;
    int   mon_due;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int gap      = -1;

    n64adv_vin_demux #(
        .color_width_i (7),
        .line_cnt_w    (10),
        .pal_thresh    (288)
    ) dut (
        .VCLK          (VCLK),
        .nVRST         (nVRST),
        .nVDSYNC       (nVDSYNC),
        .VD_i          (VD_i),
        .vdata_o       (vdata_o),
        .vdata_valid_o (vdata_valid_o),
        .palmode_o     (palmode_o),
        .interlaced_o  (interlaced_o),
        .field_o       (field_o),
        .vinfo_valid_o (vinfo_valid_o),
        .sync_err_o    (sync_err_o)
    );

    initial VCLK = 1'b0;
    always #5 VCLK = ~VCLK;

    always @(posedge VCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge VCLK) begin
        if (vdata_valid_o === 1'b1) begin
            check("pix_expected", 32'(pix_q.size() != 0), 32'd1);
            if (pix_q.size() != 0) begin
                mon_e = pix_q.pop_front();
                check("pix_data", 32'(vdata_o), 32'(mon_e.vdata));
                check("pix_status", 32'({vinfo_valid_o, palmode_o, interlaced_o, field_o}),
                      32'(mon_e.status));
                check("pix_latency", cyc, mon_e.due);
            end
        end
        if (sync_err_o === 1'b1) begin
            check("err_expected", 32'(err_q.size() != 0), 32'd1);
            if (err_q.size() != 0) begin
                mon_due = err_q.pop_front();
                check("err_latency", cyc, mon_due);
            end
        end
    end

    task automatic put_byte(input logic s, input logic [6:0] d);
        @(negedge VCLK);
        nVDSYNC = s;
        VD_i    = d;
    endtask

    task automatic send_frame(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g,
                              input logic [6:0] b, input logic [3:0] st);
        put_byte(1'b0, {3'b000, s});
        put_byte(1'b1, r);
        put_byte(1'b1, g);
        put_byte(1'b1, b);
        pix_q.push_back('{vdata: {s, r, g, b}, status: st, due: cyc + 3});
        gap = 0;
    endtask

    // Idle bus; the second consecutive gap byte after a pixel is an error.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            put_byte(1'b1, 7'h00);
            if (gap >= 0) begin
                gap++;
                if (gap == 2) err_q.push_back(cyc + 2);
            end
        end
    endtask

    task automatic apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge VCLK);
            nVRST   = 1'b0;
            nVDSYNC = 1'($urandom);
            VD_i    = 7'($urandom);
        end
        @(negedge VCLK);
        check("rst_vdata", 32'(vdata_o), 32'h01E00000);
        check("rst_valid", 32'(vdata_valid_o), 32'd0);
        check("rst_err", 32'(sync_err_o), 32'd0);
        check("rst_vinfo", 32'({vinfo_valid_o, palmode_o, interlaced_o, field_o}), 32'd0);
        nVRST   = 1'b1;
        nVDSYNC = 1'b1;
        VD_i    = 7'h00;
        gap     = -1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && (pix_q.size() + err_q.size()) != 0; i++) @(negedge VCLK);
        check("drain_pix", pix_q.size(), 0);
        check("drain_err", err_q.size(), 0);
    endtask

    // Fields of n[f] lines; each line is an nHSYNC-low frame then an all-high frame.
    // st_after[f] is the status once field f has closed; the frame right before
    // a closing sync already sees it because both land on the same edge.
    task automatic run_fields(input int n0, input int n1, input int n2,
                              input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2);
        int         n[3];
        logic [3:0] st_after[3];
        logic [3:0] cur;
        n[0] = n0; n[1] = n1; n[2] = n2;
        st_after[0] = s0; st_after[1] = s1; st_after[2] = s2;
        cur = 4'h0;
        for (int f = 0; f < 3; f++) begin
            for (int l = 0; l < n[f]; l++) begin
                if (l == 0 && f > 0) send_frame(4'b0100, 7'(l), 7'(f), 7'h40, cur);
                else                 send_frame(4'b1100, 7'(l), 7'(f), 7'h40, cur);
                if (l == n[f] - 1) cur = st_after[f];
                send_frame(4'b1111, 7'h01, 7'h02, 7'h03, cur);
            end
        end
        send_frame(4'b0100, 7'h7E, 7'h03, 7'h40, cur);
        send_frame(4'b1111, 7'h01, 7'h02, 7'h03, cur);
    endtask

    initial begin
        nVRST   = 1'b0;
        nVDSYNC = 1'b1;
        VD_i    = 7'h00;

        // 1: reset with random bus activity
        apply_reset();
        idle(2);

        // 2: clean pixel
        send_frame(4'hF, 7'h55, 7'h2A, 7'h7F, 4'h0);

        // 3: short frame, then a full frame
        put_byte(1'b0, 7'h0F);
        put_byte(1'b1, 7'h11);
        put_byte(1'b0, 7'h0F);
        err_q.push_back(cyc + 2);
        put_byte(1'b1, 7'h22);
        put_byte(1'b1, 7'h33);
        put_byte(1'b1, 7'h44);
        pix_q.push_back('{vdata: {4'hF, 7'h22, 7'h33, 7'h44}, status: 4'h0, due: cyc + 3});
        gap = 0;

        // 4: long gap after a pixel
        send_frame(4'hF, 7'h01, 7'h02, 7'h03, 4'h0);
        idle(3);
        wait_drain();

        // 5: NTSC progressive
        apply_reset();
        run_fields(263, 263, 263, 4'b0000, 4'b1000, 4'b1000);
        idle(3);
        wait_drain();
        check("ntsc_status", 32'({vinfo_valid_o, palmode_o, interlaced_o, field_o}), 32'h8);

        // 6: PAL interlaced, then reset mid-field with a partial pixel in flight
        apply_reset();
        run_fields(312, 313, 312, 4'b0000, 4'b1111, 4'b1110);
        put_byte(1'b0, 7'h0F);
        put_byte(1'b1, 7'h12);
        apply_reset();
        send_frame(4'hF, 7'h0A, 7'h0B, 7'h0C, 4'h0);
        idle(3);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
